// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state
// encoding, requester ids, default widths and the round-robin pick rule.
package mem_access_ctrl_pkg;

    localparam int AW_DEF = 24;
    localparam int DW_DEF = 24;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD_MAR = 2'd1;
    localparam logic [1:0] ACCESS   = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // A lone requester wins outright; on a tie the one not served last wins.
    function automatic logic rr_pick(input logic req_if, input logic req_ls,
                                     input logic last_grant);
        if (req_if && req_ls)
            return ~last_grant;
        else if (req_ls)
            return REQ_LS;
        else
            return REQ_IF;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational; the history bit
// only moves when the controller finishes a transaction.
module mem_access_ctrl_rr_arbiter2
    import mem_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_ls,
    input  logic update,
    input  logic update_id,
    output logic grant_valid,
    output logic grant_id
);

    logic last_grant_reg;

    // Remember who was served last; IF after reset so the first tie goes to LS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_reg <= REQ_IF;
        else if (update)
            last_grant_reg <= update_id;
    end

    assign grant_valid = req_if | req_ls;
    assign grant_id    = rr_pick(req_if, req_ls, last_grant_reg);

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the MAR and data memory between instruction fetch and load/store.
// One transaction at a time: arbitrate, load MAR, hold the strobe for
// WAIT_CYCLES, then ack. Strobes and acks decode straight from the state so
// that an asynchronous reset drops them without waiting for a clock edge.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          mar_write,
    output logic [AW-1:0] mar_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Counter is loaded with WAIT_CYCLES-1 so ACCESS lasts WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_reg;
    logic [3:0]    count_reg;
    logic          id_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] ls_rdata_reg;

    logic grant_valid;
    logic grant_id;
    logic done_pulse;

    assign done_pulse = (state_reg == DONE);

    mem_access_ctrl_rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (if_req),
        .req_ls     (ls_req),
        .update     (done_pulse),
        .update_id  (id_reg),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // FSM, wait counter and latched copies of the granted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            id_reg       <= REQ_IF;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        id_reg    <= grant_id;
                        addr_reg  <= (grant_id == REQ_LS) ? ls_addr : if_addr;
                        we_reg    <= (grant_id == REQ_LS) && ls_we;
                        wdata_reg <= (grant_id == REQ_LS) ? ls_wdata : '0;
                        state_reg <= LOAD_MAR;
                    end
                end
                LOAD_MAR: begin
                    count_reg <= CNT_INIT;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (count_reg == 4'd0) begin
                        // Read data lands in the requester's output register so
                        // it is valid in the same cycle as the ack.
                        if (!we_reg) begin
                            if (id_reg == REQ_IF)
                                if_rdata_reg <= mem_rdata;
                            else
                                ls_rdata_reg <= mem_rdata;
                        end
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mar_write = (state_reg == LOAD_MAR);
    assign mar_addr  = mar_write ? addr_reg : '0;
    assign mem_re    = (state_reg == ACCESS) && !we_reg;
    assign mem_we    = (state_reg == ACCESS) && we_reg;
    assign mem_wdata = mem_we ? wdata_reg : '0;
    assign if_ack    = done_pulse && (id_reg == REQ_IF);
    assign ls_ack    = done_pulse && (id_reg == REQ_LS);
    assign if_rdata  = if_rdata_reg;
    assign ls_rdata  = ls_rdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Three instances share inputs:
// WAIT_CYCLES = 2 (main), 1 and 15.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [23:0] if_addr = '0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [23:0] ls_addr = '0;
    logic [23:0] ls_wdata = '0;
    logic [23:0] mem_rdata = '0;

    logic        if_ack, ls_ack, mar_write, mem_re, mem_we, busy;
    logic [23:0] if_rdata, ls_rdata, mar_addr, mem_wdata;

    logic        w1_if_ack, w1_ls_ack, w1_mar_write, w1_mem_re, w1_mem_we, w1_busy;
    logic [23:0] w1_if_rdata, w1_ls_rdata, w1_mar_addr, w1_mem_wdata;
    logic        w15_if_ack, w15_ls_ack, w15_mar_write, w15_mem_re, w15_mem_we, w15_busy;
    logic [23:0] w15_if_rdata, w15_ls_rdata, w15_mar_addr, w15_mem_wdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(24), .DW(24), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mar_write(mar_write), .mar_addr(mar_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_ctrl #(.AW(24), .DW(24), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(w1_if_ack), .if_rdata(w1_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(w1_ls_ack), .ls_rdata(w1_ls_rdata),
        .mar_write(w1_mar_write), .mar_addr(w1_mar_addr), .mem_re(w1_mem_re),
        .mem_we(w1_mem_we), .mem_wdata(w1_mem_wdata), .mem_rdata(mem_rdata), .busy(w1_busy)
    );

    mem_access_ctrl #(.AW(24), .DW(24), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(w15_if_ack), .if_rdata(w15_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(w15_ls_ack), .ls_rdata(w15_ls_rdata),
        .mar_write(w15_mar_write), .mar_addr(w15_mar_addr), .mem_re(w15_mem_re),
        .mem_we(w15_mem_we), .mem_wdata(w15_mem_wdata), .mem_rdata(mem_rdata), .busy(w15_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hold reset across two rising edges, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Watch one transaction on the main instance. Cycle n counts falling edges
    // after the request was presented; returns the ack cycle (-1 on timeout).
    task automatic observe(input bit is_ls, output int lat, output int n_mar,
                           output int n_re, output int n_we, output logic [23:0] maddr,
                           output logic [23:0] wd, output bit both);
        lat = -1; n_mar = 0; n_re = 0; n_we = 0; maddr = '0; wd = '0; both = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mar_write) begin n_mar++; maddr = mar_addr; end
            if (mem_re) n_re++;
            if (mem_we) begin n_we++; wd = mem_wdata; end
            if (if_ack && ls_ack) both = 1;
            if (is_ls ? ls_ack : if_ack) begin lat = n; break; end
        end
    endtask

    initial begin
        int lat, n_mar, n_re, n_we;
        logic [23:0] maddr, wd;
        bit both;

        // ---- reset state ----
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_strobes", {mar_write, mem_re, mem_we, if_ack, ls_ack}, 0);
        chk("rst_mar_addr", mar_addr, 0);

        // ---- single IF read ----
        if_req = 1; if_addr = 24'd100; mem_rdata = 24'hABCDEF;
        observe(0, lat, n_mar, n_re, n_we, maddr, wd, both);
        if_req = 0;
        $display("txn IF read addr=%0d lat=%0d rdata=%h", 100, lat, if_rdata);
        chk("if_lat", lat, 4);
        chk("if_mar_cycles", n_mar, 1);
        chk("if_mar_addr", maddr, 24'd100);
        chk("if_re_cycles", n_re, 2);
        chk("if_we_cycles", n_we, 0);
        chk("if_rdata", if_rdata, 24'hABCDEF);
        @(negedge clk);
        chk("if_idle_busy", busy, 0);

        // ---- LS load, then LS store ----
        ls_req = 1; ls_we = 0; ls_addr = 24'd7; mem_rdata = 24'h123456;
        observe(1, lat, n_mar, n_re, n_we, maddr, wd, both);
        ls_req = 0;
        $display("txn LS load addr=%0d lat=%0d rdata=%h", 7, lat, ls_rdata);
        chk("ld_lat", lat, 4);
        chk("ld_rdata", ls_rdata, 24'h123456);
        chk("ld_if_rdata_kept", if_rdata, 24'hABCDEF);

        @(negedge clk);
        ls_req = 1; ls_we = 1; ls_addr = 24'd32; ls_wdata = 24'h000055; mem_rdata = 24'hFFFFFF;
        observe(1, lat, n_mar, n_re, n_we, maddr, wd, both);
        ls_req = 0; ls_we = 0;
        $display("txn LS store addr=%0d lat=%0d wdata=%h", 32, lat, wd);
        chk("st_lat", lat, 4);
        chk("st_mar_addr", maddr, 24'd32);
        chk("st_we_cycles", n_we, 2);
        chk("st_wdata", wd, 24'h000055);
        chk("st_re_cycles", n_re, 0);
        chk("st_ls_rdata_kept", ls_rdata, 24'h123456);

        // ---- both requesting from reset: LS, IF, LS, IF every 5 cycles ----
        begin
            int ack_n[4];
            bit ack_ls[4];
            int na = 0;
            bit both_seen = 0;
            do_reset();
            if_req = 1; if_addr = 24'd11; ls_req = 1; ls_we = 0; ls_addr = 24'd22;
            mem_rdata = 24'h0F0F0F;
            for (int n = 1; n <= 19; n++) begin
                @(negedge clk);
                if (if_ack && ls_ack) both_seen = 1;
                if (if_ack || ls_ack) begin
                    if (na < 4) begin ack_n[na] = n; ack_ls[na] = ls_ack; end
                    na++;
                    $display("txn RR ack %s at cycle %0d", ls_ack ? "LS" : "IF", n);
                end
            end
            if_req = 0; ls_req = 0;
            chk("rr_count", na, 4);
            for (int i = 0; i < 4 && i < na; i++) begin
                chk($sformatf("rr_cycle%0d", i), ack_n[i], 4 + 5 * i);
                chk($sformatf("rr_is_ls%0d", i), ack_ls[i], (i % 2 == 0) ? 1 : 0);
            end
            chk("rr_no_double_ack", both_seen, 0);
        end

        // ---- IF raised during LS ACCESS waits for the next IDLE ----
        begin
            int lsn = -1, marn = -1, ifn = -1;
            logic [23:0] if_mar = '0;
            @(negedge clk);
            ls_req = 1; ls_we = 0; ls_addr = 24'd300; mem_rdata = 24'h777777;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (n == 2) begin
                    chk("wait_ls_in_access", mem_re, 1);
                    if_req = 1; if_addr = 24'd400;
                end
                if (ls_ack) begin lsn = n; ls_req = 0; end
                if (mar_write && n > 2 && marn < 0) begin marn = n; if_mar = mar_addr; end
                if (if_ack) begin ifn = n; if_req = 0; break; end
            end
            if_req = 0; ls_req = 0;
            $display("txn wait: ls_ack=%0d if_mar=%0d if_ack=%0d", lsn, marn, ifn);
            chk("wait_ls_ack", lsn, 4);
            chk("wait_if_mar", marn, 6);
            chk("wait_if_mar_addr", if_mar, 24'd400);
            chk("wait_if_ack", ifn, 9);
            chk("wait_if_rdata", if_rdata, 24'h777777);
        end

        // ---- reset asserted during ACCESS ----
        begin
            bit ack_seen = 0;
            @(negedge clk);
            if_req = 1; if_addr = 24'd55; mem_rdata = 24'h5A5A5A;
            repeat (2) @(negedge clk);
            chk("arst_re_before", mem_re, 1);
            #1 rst_n = 0;
            #1;
            chk("arst_re_async", mem_re, 0);
            chk("arst_busy_async", busy, 0);
            if_req = 0;
            @(posedge clk);
            @(negedge clk);
            if (if_ack || ls_ack) ack_seen = 1;
            rst_n = 1;
            @(negedge clk);
            if (if_ack || ls_ack) ack_seen = 1;
            $display("txn async reset in ACCESS, busy=%0b", busy);
            chk("arst_no_ack", ack_seen, 0);
            chk("arst_busy", busy, 0);
            chk("arst_outputs", {mar_write, mem_re, mem_we, if_ack, ls_ack}, 0);
            chk("arst_buses", {mar_addr, mem_wdata} , 0);
            chk("arst_rdata", {if_rdata, ls_rdata} != 48'd0, 0);
        end

        // ---- WAIT_CYCLES = 1 and 15 builds ----
        begin
            int lat1 = -1, lat15 = -1, re1 = 0, re15 = 0;
            do_reset();
            if_req = 1; if_addr = 24'h42; mem_rdata = 24'h010203;
            for (int n = 1; n <= 25; n++) begin
                @(negedge clk);
                if (lat1 < 0) begin
                    if (w1_mem_re) re1++;
                    if (w1_if_ack) lat1 = n;
                end
                if (lat15 < 0) begin
                    if (w15_mem_re) re15++;
                    if (w15_if_ack) lat15 = n;
                end
                if (lat1 >= 0 && lat15 >= 0) break;
            end
            if_req = 0;
            $display("txn W1 lat=%0d re=%0d, W15 lat=%0d re=%0d", lat1, re1, lat15, re15);
            chk("w1_lat", lat1, 3);
            chk("w1_re_width", re1, 1);
            chk("w15_lat", lat15, 17);
            chk("w15_re_width", re15, 15);
            chk("w15_rdata", w15_if_rdata, 24'h010203);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the memory address register (MAR) and data memory for the processor.
- Shares them between two requesters: instruction fetch (IF) and load/store (LS).
- Grants one requester at a time, loads the MAR, holds the memory strobe for a fixed number of wait states, then returns read data and a one-cycle ack.
- Sits between the core's fetch/LSU and the MAR + DMEM pair.

Parameters:
- AW, 24, address width; matches the MAR width.
- DW, 24, data word width.
- WAIT_CYCLES, 2, memory access cycles per transaction; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; level, held until if_ack.
- if_addr  input  AW  fetch address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse; fetch done, if_rdata valid in the same cycle.
- if_rdata  output  DW  fetched word; holds until the next IF completion.
- ls_req  input  1  load/store request; level, held until ls_ack.
- ls_we  input  1  1 = store, 0 = load; stable while ls_req is high.
- ls_addr  input  AW  load/store address.
- ls_wdata  input  DW  store data.
- ls_ack  output  1  one-cycle pulse; LS done, ls_rdata valid on loads.
- ls_rdata  output  DW  loaded word; holds until the next LS load completion.
- mar_write  output  1  MAR load enable.
- mar_addr  output  AW  address presented to the MAR.
- mem_re  output  1  DMEM read strobe.
- mem_we  output  1  DMEM write strobe.
- mem_wdata  output  DW  DMEM write data.
- mem_rdata  input  DW  DMEM read data; valid while mem_re is high.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs = 0, including if_rdata and ls_rdata.
  - last_grant = IF, so the first tie goes to LS.
  - Counter = 0.
- FSM states: IDLE, LOAD_MAR, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the one that is not last_grant (round-robin).
  - On a grant: latch the requester id, address, we (IF is always read) and wdata into internal registers, then go to LOAD_MAR.
- LOAD_MAR:
  - mar_write = 1 and mar_addr = latched address for exactly 1 cycle.
  - Go to ACCESS; counter = WAIT_CYCLES-1.
- ACCESS:
  - Reads: mem_re = 1. Writes: mem_we = 1 and mem_wdata = latched wdata.
  - Strobes hold for WAIT_CYCLES cycles.
  - Counter decrements each cycle. When the counter is 0: capture mem_rdata into an internal register (reads only) and go to DONE.
- DONE:
  - Pulse the granted requester's ack for 1 cycle.
  - Update that requester's rdata output on reads; stores leave ls_rdata unchanged.
  - Set last_grant = granted id.
  - Go to IDLE.
- Latency: request sampled in IDLE at edge k → ack is high in cycle k+2+WAIT_CYCLES.
- Throughput: one transaction per 3+WAIT_CYCLES cycles; IDLE always spends at least 1 cycle re-arbitrating.
- Strobe rules:
  - mar_write, mem_re and mem_we are mutually exclusive.
  - Strobes are never asserted in IDLE or DONE.
  - if_ack and ls_ack are never high together.
- Protocol violations:
  - Request dropped mid-transaction: the transaction completes and the ack still pulses.
  - Inputs change after grant: no effect; the latched copies are used.
- A new request arriving while busy waits; it is arbitrated in the next IDLE.
- Reset asserted mid-operation: immediate return to IDLE; strobes and acks go low asynchronously; the in-flight transaction is discarded with no ack.
- Address and data pass through unmodified; no arithmetic on the address.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, LOAD_MAR=2'd1, ACCESS=2'd2, DONE=2'd3.
  - Requester ids: REQ_IF=1'b0, REQ_LS=1'b1.
  - AW/DW defaults.
- Sub-module rr_arbiter2: two request inputs, last_grant state, grant output.
  - Combinational grant; last_grant updates on an update strobe driven from DONE.
- FSM, counter and datapath latches stay in mem_access_ctrl.

Test Plan:
- Single IF read, addr 24'd100, WAIT_CYCLES=2, mem_rdata=24'hABCDEF → mar_write is high 1 cycle with mar_addr=100; mem_re is high 2 cycles; if_ack pulses 4 cycles after the request is sampled; if_rdata=24'hABCDEF.
- LS store, addr 24'd32, wdata 24'h000055 → mem_we high 2 cycles with mem_wdata=24'h000055; ls_ack pulses once; mem_re never asserted; ls_rdata unchanged.
- Both requesting from reset, held continuously → grant order LS, IF, LS, IF; acks alternate; each gap is 5 cycles; never both acks together.
- IF request raised during an LS ACCESS → IF waits; its mar_write appears 2 cycles after ls_ack (DONE→IDLE→LOAD_MAR).
- rst_n pulled low in ACCESS → mem_re drops without waiting for a clock edge; no ack; after release, busy=0 and all outputs are 0.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds → mem strobe width is exactly 1 and 15 cycles; latency is 3 and 17 cycles.
